// File: rtl/soc_ram_pkg.sv
// Shared types and constants for the single-port SoC RAM controller and its
// clear sequencer.
package soc_ram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;

  // Word-index width; at least one bit so a single-word RAM still has a counter.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/soc_ram_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word once, then idles until the
// next reset. busy_o is high for the whole walk.
module soc_ram_clear_seq
  import soc_ram_pkg::*;
#(
  parameter  int DEPTH      = 128,
  parameter  int INIT_CLEAR = 1,
  localparam int CW         = addr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          srst_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [CW-1:0] clr_addr_o
);

  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

  ram_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o     = (state_q == CLEAR);
    clr_we_o   = (state_q == CLEAR);
    clr_addr_o = cnt_q;
  end

endmodule

// File: rtl/soc_ram_sp_ctl.sv
// Single-port synchronous RAM with byte-lane write enables, selectable
// read-during-write policy, optional output stage and post-reset clear.
module soc_ram_sp_ctl
  import soc_ram_pkg::*;
#(
  parameter  int ADDR_MSB   = 6,
  parameter  int MEM_SIZE   = 256,
  parameter  int DATA_WIDTH = 16,
  parameter  int RDW_MODE   = 0,
  parameter  int OUT_REG    = 0,
  parameter  int INIT_CLEAR = 1,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int DEPTH      = MEM_SIZE / NB
) (
  input  logic                  ram_clk,
  input  logic                  ram_rst,
  input  logic [ADDR_MSB:0]     ram_addr,
  input  logic                  ram_cen,
  input  logic [NB-1:0]         ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_din,
  output logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_busy,
  output logic                  ram_err
);

  localparam int AW = addr_width(DEPTH);
  localparam bit READ_FIRST = (RDW_MODE == RDW_READ_FIRST);
  // One extra bit so DEPTH itself is representable when it equals 2**(ADDR_MSB+1).
  localparam logic [ADDR_MSB+1:0] DEPTH_A = (ADDR_MSB + 2)'(DEPTH);

  logic                  clr_we;
  logic [AW-1:0]         clr_addr;
  logic                  access;
  logic                  in_range;
  logic                  rd_en;
  logic [AW-1:0]         mem_addr;
  logic [NB-1:0]         lane_we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  err_q;

  soc_ram_clear_seq #(
    .DEPTH      (DEPTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_clear_seq (
    .clk_i      (ram_clk),
    .srst_i     (ram_rst),
    .busy_o     (ram_busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign access   = ~ram_cen & ~ram_busy;
  assign in_range = ({1'b0, ram_addr} < DEPTH_A);
  assign rd_en    = access & in_range & ~ram_rst;

  // The sequencer owns the array port while busy; reset suppresses every write.
  always_comb begin
    mem_addr = AW'(ram_addr);
    lane_we  = '0;
    wdata    = ram_din;
    if (!ram_rst) begin
      if (ram_busy) begin
        mem_addr = clr_addr;
        lane_we  = {NB{clr_we}};
        wdata    = '0;
      end else if (rd_en) begin
        lane_we = ~ram_wen;
      end
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_lane_q;

    always_ff @(posedge ram_clk) begin
      if (lane_we[gi]) begin
        mem[mem_addr] <= wdata[8*gi +: 8];
      end
    end

    // Written lanes bypass the array in write-first mode; unwritten lanes
    // always return their stored byte.
    always_ff @(posedge ram_clk) begin
      if (ram_rst) begin
        rd_lane_q <= '0;
      end else if (rd_en) begin
        if (!READ_FIRST && !ram_wen[gi]) begin
          rd_lane_q <= ram_din[8*gi +: 8];
        end else begin
          rd_lane_q <= mem[mem_addr];
        end
      end
    end

    assign rd_word[8*gi +: 8] = rd_lane_q;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] pipe_q;

    always_ff @(posedge ram_clk) begin
      if (ram_rst) begin
        rd_vld_q <= 1'b0;
        pipe_q   <= '0;
      end else begin
        rd_vld_q <= rd_en;
        if (rd_vld_q) begin
          pipe_q <= rd_word;
        end
      end
    end

    assign ram_dout = pipe_q;
  end else begin : g_no_out_reg
    assign ram_dout = rd_word;
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= access & ~in_range;
    end
  end

  assign ram_err = err_q;

endmodule

// File: tb/tb_soc_ram_sp_ctl.sv
// Directed bench: clear sequencing with reset restart, byte lanes, both
// read-during-write policies, out-of-range flag and the output pipeline.
module tb_soc_ram_sp_ctl;

  logic clk;
  logic rst;

  logic [7:0]  addr_ab;
  logic        cen_ab;
  logic [1:0]  wen_ab;
  logic [15:0] din_ab;
  logic [15:0] dout_a, dout_b;
  logic        busy_a, busy_b, err_a, err_b;

  logic [6:0]  addr_c;
  logic        cen_c;
  logic [3:0]  wen_c;
  logic [31:0] din_c;
  logic [31:0] dout_c;
  logic        busy_c, err_c;

  int n_cmp = 0;
  int n_err = 0;

  soc_ram_sp_ctl #(
    .ADDR_MSB(7), .MEM_SIZE(256), .DATA_WIDTH(16),
    .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)
  ) u_dut_a (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr_ab), .ram_cen(cen_ab),
    .ram_wen(wen_ab), .ram_din(din_ab), .ram_dout(dout_a),
    .ram_busy(busy_a), .ram_err(err_a)
  );

  soc_ram_sp_ctl #(
    .ADDR_MSB(7), .MEM_SIZE(256), .DATA_WIDTH(16),
    .RDW_MODE(1), .OUT_REG(0), .INIT_CLEAR(1)
  ) u_dut_b (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr_ab), .ram_cen(cen_ab),
    .ram_wen(wen_ab), .ram_din(din_ab), .ram_dout(dout_b),
    .ram_busy(busy_b), .ram_err(err_b)
  );

  soc_ram_sp_ctl #(
    .ADDR_MSB(6), .MEM_SIZE(512), .DATA_WIDTH(32),
    .RDW_MODE(0), .OUT_REG(1), .INIT_CLEAR(1)
  ) u_dut_c (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr_c), .ram_cen(cen_c),
    .ram_wen(wen_c), .ram_din(din_c), .ram_dout(dout_c),
    .ram_busy(busy_c), .ram_err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        cen;
    logic [1:0]  wen;
    logic [15:0] din;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_err;
  } vec_t;

  vec_t vecs[24];
  int   nv = 0;

  task automatic add_vec(input logic [7:0] a, input logic c, input logic [1:0] w,
                         input logic [15:0] d, input logic [15:0] ea,
                         input logic [15:0] eb, input logic ee);
    vec_t v;
    v.addr = a; v.cen = c; v.wen = w; v.din = d;
    v.exp_a = ea; v.exp_b = eb; v.exp_err = ee;
    vecs[nv] = v;
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    rst = 1'b1;
    addr_ab = '0; cen_ab = 1'b1; wen_ab = 2'b11; din_ab = '0;
    addr_c  = '0; cen_c  = 1'b1; wen_c  = 4'hF;  din_c  = '0;

    // Stimulus table: each row is one edge; expectations are after that edge.
    add_vec(8'h7F, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    add_vec(8'h10, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    add_vec(8'h05, 1'b0, 2'b00, 16'hA5C3, 16'hA5C3, 16'h0000, 1'b0);
    add_vec(8'h05, 1'b0, 2'b01, 16'h1200, 16'h12C3, 16'hA5C3, 1'b0);
    add_vec(8'h05, 1'b0, 2'b11, 16'h0000, 16'h12C3, 16'h12C3, 1'b0);
    add_vec(8'h05, 1'b0, 2'b10, 16'h0077, 16'h1277, 16'h12C3, 1'b0);
    add_vec(8'h05, 1'b0, 2'b11, 16'h0000, 16'h1277, 16'h1277, 1'b0);
    add_vec(8'h09, 1'b0, 2'b00, 16'h1111, 16'h1111, 16'h0000, 1'b0);
    add_vec(8'h09, 1'b1, 2'b00, 16'h3333, 16'h1111, 16'h0000, 1'b0);
    add_vec(8'h09, 1'b0, 2'b00, 16'h2222, 16'h2222, 16'h1111, 1'b0);
    add_vec(8'h09, 1'b0, 2'b11, 16'h0000, 16'h2222, 16'h2222, 1'b0);
    add_vec(8'h7F, 1'b0, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    add_vec(8'h80, 1'b0, 2'b00, 16'hBEEF, 16'hFFFF, 16'h0000, 1'b1);
    add_vec(8'h80, 1'b1, 2'b00, 16'hBEEF, 16'hFFFF, 16'h0000, 1'b0);
    add_vec(8'h7F, 1'b0, 2'b11, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);
    add_vec(8'hFF, 1'b0, 2'b11, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);
    add_vec(8'h7F, 1'b0, 2'b11, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);
    add_vec(8'h00, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    add_vec(8'h00, 1'b0, 2'b11, 16'hABCD, 16'h0000, 16'h0000, 1'b0);
    add_vec(8'h00, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // Reset state.
    repeat (3) tick();
    check("rst_dout_a", dout_a, 32'h0);
    check("rst_dout_b", dout_b, 32'h0);
    check("rst_dout_c", dout_c, 32'h0);
    check("rst_err_a",  err_a,  32'h0);
    check("rst_busy_a", busy_a, 32'h1);
    check("rst_busy_c", busy_c, 32'h1);
    $display("reset: dout_a=0x%0h busy_a=%0b err_a=%0b", dout_a, busy_a, err_a);

    // First clear run, interrupted by reset at clear cycle 50.
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i >= 10 && i < 20) begin
        cen_ab = 1'b0; addr_ab = 8'h10; wen_ab = 2'b00; din_ab = 16'h5555;
      end else if (i == 20) begin
        cen_ab = 1'b0; addr_ab = 8'h80; wen_ab = 2'b00;
      end else begin
        cen_ab = 1'b1;
      end
      tick();
      check("clr1_busy", busy_a, 32'h1);
      check("clr1_err",  err_a,  32'h0);
      check("clr1_dout", dout_a, 32'h0);
    end
    $display("clear run 1: 50 cycles, busy_a=%0b", busy_a);

    cen_ab = 1'b1;
    rst = 1'b1;
    tick();
    check("midclr_rst_busy", busy_a, 32'h1);
    $display("reset mid-clear: busy_a=%0b", busy_a);
    rst = 1'b0;

    // Full restarted clear; accesses late in the walk must be discarded.
    cnt = 0;
    do begin
      if (cnt >= 100 && cnt < 110) begin
        cen_ab = 1'b0; addr_ab = 8'h10; wen_ab = 2'b00; din_ab = 16'h5555;
      end else if (cnt == 110) begin
        cen_ab = 1'b0; addr_ab = 8'h90; wen_ab = 2'b00;
      end else begin
        cen_ab = 1'b1;
      end
      tick();
      cnt++;
      check("clr2_err",  err_a,  32'h0);
      check("clr2_dout", dout_a, 32'h0);
    end while (busy_a && cnt < 400);
    cen_ab = 1'b1;
    check("clr2_busy_cycles", cnt, 32'd128);
    check("clr2_busy_b", busy_b, 32'h0);
    check("clr2_busy_c", busy_c, 32'h0);
    $display("clear run 2: busy cycles=%0d", cnt);

    // Table-driven vectors on the two 16-bit instances.
    for (int i = 0; i < nv; i++) begin
      addr_ab = vecs[i].addr; cen_ab = vecs[i].cen;
      wen_ab  = vecs[i].wen;  din_ab = vecs[i].din;
      tick();
      check($sformatf("vec%0d_dout_a", i), dout_a, {16'h0, vecs[i].exp_a});
      check($sformatf("vec%0d_dout_b", i), dout_b, {16'h0, vecs[i].exp_b});
      check($sformatf("vec%0d_err_a", i),  err_a,  {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_err_b", i),  err_b,  {31'h0, vecs[i].exp_err});
      $display("vec %0d: addr=0x%0h cen=%0b wen=%b din=0x%0h -> dout_a=0x%0h dout_b=0x%0h err=%0b",
               i, vecs[i].addr, vecs[i].cen, vecs[i].wen, vecs[i].din, dout_a, dout_b, err_a);
    end
    cen_ab = 1'b1;

    // Output pipeline: write, read a zero word, then read the written word.
    addr_c = 7'd3; cen_c = 1'b0; wen_c = 4'h0; din_c = 32'hDEADBEEF;
    tick();
    check("pipe_wr_e1", dout_c, 32'h0);
    $display("pipe write addr=3: dout_c=0x%0h", dout_c);
    addr_c = 7'd0; wen_c = 4'hF; din_c = '0;
    tick();
    check("pipe_wr_e2", dout_c, 32'hDEADBEEF);
    $display("pipe read addr=0: dout_c=0x%0h", dout_c);
    cen_c = 1'b1;
    tick();
    check("pipe_rd0", dout_c, 32'h0);
    tick();
    check("pipe_idle_hold0", dout_c, 32'h0);
    $display("pipe idle: dout_c=0x%0h", dout_c);
    addr_c = 7'd3; cen_c = 1'b0; wen_c = 4'hF;
    tick();
    check("pipe_rd_e1", dout_c, 32'h0);
    $display("pipe read addr=3: dout_c=0x%0h", dout_c);
    cen_c = 1'b1;
    tick();
    check("pipe_rd_e2", dout_c, 32'hDEADBEEF);
    repeat (2) tick();
    check("pipe_rd_hold", dout_c, 32'hDEADBEEF);
    check("pipe_err", err_c, 32'h0);
    $display("pipe hold: dout_c=0x%0h err_c=%0b", dout_c, err_c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/soc_ram_sp_ctl.md
# soc_ram_sp_ctl

Parametrised single-port synchronous SoC RAM with generic data width, per-byte active-low write enables, and a selectable read-during-write policy. It has an optional output pipeline register, a hardware clear sequencer that runs after reset, and an out-of-range access flag. It replaces the fixed 16-bit single-port RAM in the SoC memory map for program and data memories, and is a drop-in when `DATA_WIDTH=16`, `OUT_REG=0`, `RDW_MODE=0` and `INIT_CLEAR=0`.

## Interface
- `ADDR_MSB`, default 6: MSB of the word address bus.
- `MEM_SIZE`, default 256: memory size in bytes.
- `DATA_WIDTH`, default 16: word width in bits; must be a multiple of 8. `NB = DATA_WIDTH/8` and `DEPTH = MEM_SIZE/NB`.
- `RDW_MODE`, default 0: 0 = write-first (read returns the newly written data); 1 = read-first (read returns the old data).
- `OUT_REG`, default 0: 1 adds one output pipeline stage.
- `INIT_CLEAR`, default 1: 1 enables zero-fill of every word after reset.
- `ram_clk`, in, 1: RAM clock. Only clock.
- `ram_rst`, in, 1: reset. **Synchronous, active-high.**
- `ram_addr`, in, `ADDR_MSB+1`: word address.
- `ram_cen`, in, 1: chip enable, active low.
- `ram_wen`, in, `NB`: byte write enables, active low; bit i controls `ram_din[8i+7:8i]`.
- `ram_din`, in, `DATA_WIDTH`: write data.
- `ram_dout`, out, `DATA_WIDTH`: read data.
- `ram_busy`, out, 1: clear sequence in progress; accesses are ignored while high.
- `ram_err`, out, 1: one-cycle pulse on an out-of-range access.

## Operation
- **Access definition:** an access is an edge where `ram_cen=0` and `ram_busy=0`.
- **Access with `ram_addr < DEPTH`:**
  - Every lane with `ram_wen[i]=0` is written.
  - Lanes with `ram_wen[i]=1` keep their contents.
  - A read is always performed, for all `ram_wen` values.
- **Read-during-write:**
  - `RDW_MODE=0`: `ram_dout` returns the merged new word.
  - `RDW_MODE=1`: `ram_dout` returns the pre-write word.
- **Out-of-range access (`ram_addr >= DEPTH`):**
  - No write; `ram_dout` holds its value.
  - `ram_err` pulses high for exactly one cycle.
- **No access:** `ram_dout` holds its last value; no write, no error.
- **Sequencer states:** `IDLE`, `CLEAR`.
  - Reset sets the state to `CLEAR` if `INIT_CLEAR=1`, otherwise `IDLE`. The clear address counter resets to 0.
  - In `CLEAR`, each edge writes 0 to word[cnt] and increments `cnt`.
  - When `cnt = DEPTH-1` is written, the state moves to `IDLE`.
  - `IDLE` is terminal until the next reset.
- **Accesses during `CLEAR`:** discarded silently. No write, no `ram_err`, and `ram_dout` is unchanged.
- **Reset mid-clear:** restarts the sequence from address 0.
- **Reset mid-access:** the write at that edge is suppressed.
- **Memory contents:** not reset unless `INIT_CLEAR=1`. Without clearing they are undefined (X in simulation).

## Timing
- **Reset values:**
  - `ram_dout` = 0, including the pipeline register.
  - `ram_err` = 0.
  - `ram_busy` = `INIT_CLEAR`.
  - State = `CLEAR` or `IDLE` as above.
- **Clear duration:** with `ram_rst` sampled low at edge 0, clear writes occur at edges 0 to `DEPTH-1`. `ram_busy` falls after edge `DEPTH-1`, so the first accepted access is at edge `DEPTH`. For the default configuration this is 128 cycles.
- **Read latency:** data appears on `ram_dout` after the access edge. This is 1 edge for `OUT_REG=0` and 2 edges for `OUT_REG=1`. Throughput is one access per cycle.
- **Write timing:** the write is visible to a read at the same address on the next access edge.
- **`ram_err` alignment:** asserted the cycle after the offending edge, independent of `OUT_REG`.
- **Pipeline behaviour with `OUT_REG=1`:** the stage updates only when its input stage was loaded by an access. The output therefore holds between accesses and on out-of-range accesses.

## Structure
- **Package `soc_ram_pkg`:**
  - Constants `RDW_WRITE_FIRST = 0` and `RDW_READ_FIRST = 1`.
  - Sequencer state enum `ram_state_t` with values `IDLE` and `CLEAR`.
- **Sub-module `soc_ram_clear_seq`:**
  - Contains the state register, the clear counter of width `$clog2(DEPTH)`, and `ram_busy`.
  - Outputs the clear write strobe and clear address.
- **Top level:**
  - Muxes the sequencer's clear write over the user port.
  - Owns the array, lane merge, RDW logic, output register and error flag.

## Test plan
- **Clear sequence:** `INIT_CLEAR=1`, release reset, count cycles. `ram_busy` must be high for exactly 128 cycles. Afterwards, a read of address 0x7F returns 0x0000.
- **Byte-lane writes:**
  - Write 0xA5C3 to address 5 with `wen=2'b00`.
  - Write 0x1200 to address 5 with `wen=2'b01`; the next read returns 0x12C3.
  - Write 0x0077 to address 5 with `wen=2'b10`; the next read returns 0x1277.
- **Read-during-write:**
  - Address 9 holds 0x1111; write 0x2222 there.
  - With `RDW_MODE=0`, `ram_dout` shows 0x2222 one cycle later.
  - With `RDW_MODE=1`, `ram_dout` shows 0x1111.
- **Out-of-range access:**
  - Write 0xFFFF to address 0x7F, which is in range, then write 0xBEEF to address 0x80.
  - `ram_err` pulses for exactly one cycle.
  - `ram_dout` is unchanged, and address 0x7F still reads 0xFFFF.
- **Output pipeline:**
  - With `OUT_REG=1` and `DATA_WIDTH=32`, write 0xDEADBEEF to address 3, then read it back.
  - Data appears exactly 2 edges after the read edge and holds while `ram_cen=1`.
- **Reset mid-clear:**
  - Assert `ram_rst` at clear cycle 50.
  - `ram_busy` stays high, and the sequence restarts with a full 128-cycle clear.
  - An access attempted during the clear is ignored, with no `ram_err`.
